// File: rtl/com_pkg.sv
// Shared widths and FSM state encoding for the console RAM-to-stream path.
package com_pkg;
  localparam int COM_ADDR_W = 12;
  localparam int COM_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_DONE = 2'd2
  } rd_state_e;
endpackage

// File: rtl/com_skid2.sv
// Two-entry valid/ready skid buffer; output driven straight from storage, one-cycle fill latency.
// in_rdy drops only when both entries are full; the head entry holds steady while out_rdy is low.
module com_skid2 #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat
);
  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         push, pop;

  assign in_rdy  = (cnt_q != 2'd2);
  assign out_vld = (cnt_q != 2'd0);
  assign out_dat = mem_q[rd_ptr_q];
  assign push    = in_vld && in_rdy;
  assign pop     = out_vld && out_rdy;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_dat;
      wr_ptr_d        = !wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = !rd_ptr_q;
    end
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: rtl/com_ram_read.sv
// Streams dlen bytes from RAM port B to a valid/ready transmitter; first byte 2 cycles after READ, stalls hold output.
// COM_RAM_READ_CHECKSUM_EN appends an XOR-of-data byte carrying tx_last.
module com_ram_read
  import com_pkg::*;
#(
  parameter int ADDR_W = COM_ADDR_W,
  parameter int DATA_W = COM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fs,
  output logic              fd,
  input  logic [ADDR_W-1:0] ram_addr_init,
  input  logic [ADDR_W-1:0] dlen,
  output logic [ADDR_W-1:0] ram_rxa,
  input  logic [DATA_W-1:0] ram_rxd,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_last
);
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  rd_state_e         state_q, state_d;
  logic              fd_q, fd_d;
  logic [ADDR_W-1:0] ram_rxa_q, ram_rxa_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic              pend_q, pend_d;
  logic              issue, pop;
  logic              skid_in_vld, skid_in_rdy, skid_out_vld;
  logic [DATA_W:0]   skid_in_dat, skid_out_w;
`ifdef COM_RAM_READ_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
  logic              csum_sent_q, csum_sent_d;
  logic              csum_vld;
`else
  logic              pend_last_q, pend_last_d;
`endif

  assign pop = skid_out_vld && tx_ready;

`ifdef COM_RAM_READ_CHECKSUM_EN
  assign csum_vld    = (state_q == ST_READ) && !pend_q && (rem_q == '0) && !csum_sent_q;
  assign skid_in_vld = pend_q || csum_vld;
  assign skid_in_dat = pend_q ? {1'b0, ram_rxd} : {1'b1, csum_q};
`else
  assign skid_in_vld = pend_q;
  assign skid_in_dat = {pend_last_q, ram_rxd};
`endif

  always_comb begin
    state_d   = state_q;
    fd_d      = fd_q;
    ram_rxa_d = ram_rxa_q;
    rem_d     = rem_q;
    issue     = 1'b0;
`ifdef COM_RAM_READ_CHECKSUM_EN
    csum_d      = csum_q;
    csum_sent_d = csum_sent_q;
`endif
    // Issue only if the skid is sure to have room when this read's data lands next cycle.
    if (state_q == ST_READ && rem_q != '0) begin
      if (pend_q) issue = !skid_out_vld || (skid_in_rdy && pop);
      else        issue = skid_in_rdy || pop;
    end
    pend_d = issue;
`ifndef COM_RAM_READ_CHECKSUM_EN
    pend_last_d = issue && (rem_q == ONE);
`endif
    case (state_q)
      ST_IDLE: begin
        if (fs) begin
          state_d   = ST_READ;
          ram_rxa_d = ram_addr_init;
          rem_d     = dlen;
`ifdef COM_RAM_READ_CHECKSUM_EN
          csum_d      = '0;
          csum_sent_d = 1'b0;
`endif
        end
      end
      ST_READ: begin
        if (issue) begin
          ram_rxa_d = ram_rxa_q + ONE;
          rem_d     = rem_q - ONE;
        end
`ifdef COM_RAM_READ_CHECKSUM_EN
        if (pend_q) csum_d = csum_q ^ ram_rxd;
        if (csum_vld && skid_in_rdy) csum_sent_d = 1'b1;
        if (pop && skid_out_w[DATA_W]) begin
          state_d = ST_DONE;
          fd_d    = 1'b1;
        end
`else
        // Second term only fires for an empty packet: nothing left to read, in flight or queued.
        if ((pop && skid_out_w[DATA_W]) || (rem_q == '0 && !pend_q && !skid_out_vld)) begin
          state_d = ST_DONE;
          fd_d    = 1'b1;
        end
`endif
      end
      ST_DONE: begin
        if (!fs) begin
          state_d = ST_IDLE;
          fd_d    = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        fd_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      fd_q      <= 1'b0;
      ram_rxa_q <= '0;
      rem_q     <= '0;
      pend_q    <= 1'b0;
`ifdef COM_RAM_READ_CHECKSUM_EN
      csum_q      <= '0;
      csum_sent_q <= 1'b0;
`else
      pend_last_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      fd_q      <= fd_d;
      ram_rxa_q <= ram_rxa_d;
      rem_q     <= rem_d;
      pend_q    <= pend_d;
`ifdef COM_RAM_READ_CHECKSUM_EN
      csum_q      <= csum_d;
      csum_sent_q <= csum_sent_d;
`else
      pend_last_q <= pend_last_d;
`endif
    end
  end

  com_skid2 #(.W(DATA_W + 1)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (skid_in_vld),
    .in_rdy  (skid_in_rdy),
    .in_dat  (skid_in_dat),
    .out_vld (skid_out_vld),
    .out_rdy (tx_ready),
    .out_dat (skid_out_w)
  );

  assign fd       = fd_q;
  assign ram_rxa  = ram_rxa_q;
  assign tx_valid = skid_out_vld;
  assign tx_data  = skid_out_w[DATA_W-1:0];
  assign tx_last  = skid_out_w[DATA_W];
endmodule

// File: doc/com_ram_read.md
COM_RAM_READ -- requirements
Module: com_ram_read

Interface
REQ-001 Parameter ADDR_W, default 12, RAM address width and length width.
REQ-002 Parameter DATA_W, default 8, RAM and stream byte width.
REQ-003 clk  input  1  single clock for all logic; the block SHALL use one clock and a synchronous, active-low reset.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 fs  input  1  start request, level, from console.
REQ-006 fd  output  1  done flag, level, to console.
REQ-007 ram_addr_init  input  ADDR_W  first RAM address of the packet, sampled at start.
REQ-008 dlen  input  ADDR_W  byte count, sampled at start.
REQ-009 ram_rxa  output  ADDR_W  RAM read address (port B).
REQ-010 ram_rxd  input  DATA_W  RAM read data, valid one cycle after ram_rxa.
REQ-011 tx_data  output  DATA_W  stream byte to transmitter.
REQ-012 tx_valid  output  1  tx_data valid.
REQ-013 tx_ready  input  1  transmitter accepts byte when tx_valid and tx_ready are both high.
REQ-014 tx_last  output  1  marks the final byte of the packet.

Function
REQ-015 The FSM SHALL have states IDLE, READ, DONE.
REQ-016 In IDLE with fs=1, the block SHALL latch ram_addr_init and dlen and enter READ on the next edge.
REQ-017 ram_rxa SHALL equal the latched start address in the first READ cycle and SHALL increment by 1 per issued read.
REQ-018 With tx_ready held high, the first tx_valid SHALL rise 2 cycles after entering READ.
REQ-019 With tx_ready held high, throughput SHALL be one byte per cycle with no bubbles.
REQ-020 Reads SHALL be prefetched into a 2-entry skid buffer.
REQ-021 A read SHALL issue only when a buffer slot is guaranteed free on data return.
REQ-022 While tx_valid=1 and tx_ready=0, tx_data and tx_last SHALL hold stable.
REQ-023 Total bytes issued SHALL equal the latched dlen; surplus reads SHALL NOT issue.
REQ-024 ram_rxa SHALL wrap from 2^ADDR_W-1 to 0.
REQ-025 tx_last SHALL be high only with the final byte of the packet.
REQ-026 After the final byte is accepted, the FSM SHALL enter DONE.
REQ-027 In DONE, fd SHALL be 1, and the FSM SHALL return to IDLE on the first cycle fs=0, with fd=0 in IDLE.
REQ-028 Deasserting fs during READ SHALL NOT abort the transfer.
REQ-029 fs held high in DONE SHALL NOT restart the transfer.
REQ-030 dlen=0 SHALL emit no data bytes; the FSM SHALL go READ->DONE in one cycle, absent CHECKSUM_EN.
REQ-031 dlen=2^ADDR_W-1 SHALL be supported without counter overflow.

Reset
REQ-032 On rst_n=0 at a clk edge: state=IDLE, fd=0, tx_valid=0, tx_last=0, tx_data=0, ram_rxa=0; skid buffer and counters SHALL be cleared.
REQ-033 Reset during READ SHALL abort the transfer; no further bytes SHALL be emitted after reset deasserts until a new fs.

Configuration
REQ-034 Macro COM_RAM_READ_CHECKSUM_EN defined: one extra byte, the XOR of all data bytes, SHALL follow the data, with tx_last on it; dlen=0 SHALL emit the single byte 0x00.
REQ-035 Macro COM_RAM_READ_CHECKSUM_EN undefined: no checksum byte, no checksum logic; tx_last SHALL be on the final data byte.

Structure
REQ-036 The FSM state enum and ADDR_W/DATA_W defaults SHALL live in the shared com package.
REQ-037 The 2-entry skid buffer SHALL be the sub-module com_skid2 (valid/ready in and out, DATA_W+1 wide, carrying data and last).

Verification
REQ-038 Scenario, basic transfer: RAM[0x010..0x013]=0x11,0x22,0x33,0x44; addr=0x010, dlen=4, tx_ready=1 -> 0x11..0x44 on 4 consecutive cycles, first byte 2 cycles after READ, tx_last on 0x44, fd rises next cycle.
REQ-039 Scenario, backpressure: tx_ready toggled 1,0,0,1,... -> no byte lost or duplicated, tx_data held stable while stalled, order preserved.
REQ-040 Scenario, address wrap: addr=0xFFE, dlen=4 -> reads 0xFFE, 0xFFF, 0x000, 0x001.
REQ-041 Scenario, empty packet: dlen=0 -> no tx_valid and fd=1; with COM_RAM_READ_CHECKSUM_EN -> single byte 0x00 with tx_last.
REQ-042 Scenario, checksum: data 0x11,0x22,0x33,0x44 with COM_RAM_READ_CHECKSUM_EN -> fifth byte 0x44 with tx_last.
REQ-043 Scenario, reset mid-transfer: rst_n=0 after 2 of 8 bytes -> all outputs zero next cycle; a new fs restarts cleanly from the new ram_addr_init.
